parser: RTL and testbench
=========================

Name: parser

Overview:
- Byte-serial sequence parser.
- Takes a framed stream of 32-bit words carrying length-prefixed messages and emits one fixed 296-bit record per message.
- Detects truncated or malformed messages and signals them on packetLost.
- Sits between a word-stream source (valid/ready/last) and a record consumer (valid/ready).

Parameters:
- none. Bus widths are fixed: input 32 bits, record 296 bits = 8-bit length + 36 payload bytes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- dataIn  in  32  input word; byte 0 = dataIn[31:24], byte 3 = dataIn[7:0]
- dataInVal  in  1  dataIn/dataInLast valid
- dataInReady  out  1  parser can accept a word this cycle
- dataInLast  in  1  word is the final word of a packet
- dataOut  out  296 [0:295]  record: [0:7] length L, [8:295] payload bytes left-aligned (byte k at [8+8k : 15+8k]), unused bytes zero
- dataOutVal  out  1  record valid
- dataOutReady  in  1  consumer accepts record
- packetLost  out  1  one-cycle error pulse

Behaviour:
- Reset: sampled on the clock edge while reset=0.
  - Outputs: dataOut=0, dataOutVal=0, packetLost=0, dataInReady=0.
  - Internal: word buffer empty, FSM=IDLE, partial message discarded, no packetLost.
  - dataInReady may rise the first cycle after reset returns to 1.
- Word accept: on an edge with dataInVal && dataInReady, load the 4 bytes and the last flag into the buffer, byte index=0.
- Byte processing: one buffered byte per edge, in order byte0..byte3.
- Stall: no byte is processed while dataOutVal=1 && dataOutReady=0.
- dataInReady (combinational):
  - high when the buffer is empty, or
  - high when byte3 is being processed this cycle and not stalled.
  - Sustained throughput is one word per 4 cycles.
- FSM states: IDLE, PAYLOAD, DISCARD.
  - IDLE, byte 0x00: padding, skipped.
  - IDLE, byte 1..36: L=byte, payload count=0, go to PAYLOAD.
  - IDLE, byte >36: packetLost pulse, go to DISCARD.
  - PAYLOAD: store byte at payload index.
    - When index reaches L, load the record into dataOut and set dataOutVal on that same edge.
    - Unused payload bytes in the record are zero. Return to IDLE.
  - DISCARD: drop bytes until byte3 of the last word has been processed, then go to IDLE.
- End of packet: after byte3 of a word flagged last:
  - If FSM=PAYLOAD (incomplete message): packetLost pulse on the next cycle, partial data dropped, FSM=IDLE.
  - If a record completes on byte3, it is emitted normally and there is no error.
- Output handshake: the record is held stable while dataOutVal && !dataOutReady. dataOutVal clears on the edge with dataOutReady=1 unless a new record loads on that same edge.
- packetLost: exactly one cycle high per error event, independent of dataOutReady. Records already emitted from the same packet are not retracted.
- Packets never merge: the first byte after a last word is always parsed from IDLE.

Test Plan:
- Single message: word 0x03AABBCC, last=1, dataOutReady=1 -> one record with dataOut[0:7]=0x03, [8:31]=0xAABBCC, [32:295]=0; packetLost stays 0.
- Two messages plus padding: 0x02AABB01 then 0xCC000000 (last) -> records (L=2, AA BB) then (L=1, CC); no third record; packetLost=0.
- Max length: 0x24 followed by 36 bytes 0x01..0x24, spread over 10 words with 3 trailing pad bytes -> one record: [0:7]=0x24, payload bytes 0x01..0x24 filling [8:295].
- Truncation and bad length:
  - 0x05111111 (last) -> no record, one packetLost pulse.
  - 0x25xxxxxx then one more word (last), followed by packet 0x01EE0000 (last) -> one packetLost pulse, remainder dropped, then record L=1, payload 0xEE.
- Backpressure: dataOutReady=0 with input 0x01AA01BB (last) -> first record (AA) held stable, parsing stalls, dataInReady=0; raising dataOutReady delivers AA then BB, in order, with no loss.
- Reset mid-message: send 0x0A112233, pull reset low for one edge -> dataOutVal=0 and packetLost=0; a following 0x01770000 (last) yields record L=1, payload 0x77.

Source files
------------

// File: rtl/parser.sv
// Byte-serial parser: unpacks 32-bit words into length-prefixed messages and
// emits one 296-bit record (length + 36 payload bytes) per complete message.
module parser (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  dataIn,
  input  logic         dataInVal,
  output logic         dataInReady,
  input  logic         dataInLast,
  output logic [0:295] dataOut,
  output logic         dataOutVal,
  input  logic         dataOutReady,
  output logic         packetLost
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [7:0] MAX_LEN = 8'd36;

  state_t         state_q, state_d;
  logic           buf_valid_q, buf_valid_d;
  logic [31:0]    buf_data_q, buf_data_d;
  logic           buf_last_q, buf_last_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [7:0]     len_q, len_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [0:287]   payload_q, payload_d;
  logic [0:295]   out_q, out_d;
  logic           out_val_q, out_val_d;
  logic           lost_q, lost_d;

  logic           stall_s;
  logic           process_s;
  logic           eop_s;
  logic           accept_s;
  logic           ready_s;
  logic [7:0]     cur_byte_s;

  // Handshake qualifiers and selection of the byte currently being parsed
  always_comb begin
    stall_s   = out_val_q && !dataOutReady;
    process_s = buf_valid_q && !stall_s;
    eop_s     = process_s && (byte_idx_q == 2'd3) && buf_last_q;
    ready_s   = reset && (!buf_valid_q || (process_s && (byte_idx_q == 2'd3)));
    accept_s  = dataInVal && ready_s;
    case (byte_idx_q)
      2'd0:    cur_byte_s = buf_data_q[31:24];
      2'd1:    cur_byte_s = buf_data_q[23:16];
      2'd2:    cur_byte_s = buf_data_q[15:8];
      2'd3:    cur_byte_s = buf_data_q[7:0];
      default: cur_byte_s = 8'd0;
    endcase
  end

  // Next-state: word buffer, message FSM, record output and error pulse
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    byte_idx_d  = byte_idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    payload_d   = payload_q;
    out_d       = out_q;
    out_val_d   = out_val_q && !dataOutReady;
    lost_d      = 1'b0;

    if (accept_s) begin
      buf_valid_d = 1'b1;
      buf_data_d  = dataIn;
      buf_last_d  = dataInLast;
      byte_idx_d  = 2'd0;
    end else if (process_s) begin
      buf_valid_d = (byte_idx_q != 2'd3);
      byte_idx_d  = byte_idx_q + 2'd1;
    end else begin
      buf_valid_d = buf_valid_q;
    end

    if (process_s) begin
      case (state_q)
        IDLE: begin
          if (cur_byte_s == 8'd0) begin
            state_d = IDLE;
          end else if (cur_byte_s <= MAX_LEN) begin
            len_d     = cur_byte_s;
            cnt_d     = 6'd0;
            payload_d = '0;
            state_d   = PAYLOAD;
          end else begin
            lost_d  = 1'b1;
            state_d = DISCARD;
          end
        end
        PAYLOAD: begin
          payload_d[{cnt_q, 3'b000} +: 8] = cur_byte_s;
          if (({2'b00, cnt_q} + 8'd1) == len_q) begin
            out_d     = {len_q, payload_d};
            out_val_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        DISCARD: state_d = DISCARD;
        default: state_d = IDLE;
      endcase

      // A packet boundary always returns to IDLE; an open message is an error
      if (eop_s) begin
        if (state_d == PAYLOAD) begin
          lost_d = 1'b1;
        end else begin
          lost_d = lost_d;
        end
        state_d = IDLE;
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'd0;
      buf_last_q  <= 1'b0;
      byte_idx_q  <= 2'd0;
      len_q       <= 8'd0;
      cnt_q       <= 6'd0;
      payload_q   <= '0;
      out_q       <= '0;
      out_val_q   <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      byte_idx_q  <= byte_idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      payload_q   <= payload_d;
      out_q       <= out_d;
      out_val_q   <= out_val_d;
      lost_q      <= lost_d;
    end
  end

  assign dataInReady = ready_s;
  assign dataOut     = out_q;
  assign dataOutVal  = out_val_q;
  assign packetLost  = lost_q;

endmodule

// File: tb/tb_parser.sv
// Directed self-checking bench for the parser: records and error pulses are
// collected by a monitor and compared against hand-computed expectations.
module tb_parser;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  dataIn;
  logic         dataInVal;
  logic         dataInReady;
  logic         dataInLast;
  logic [0:295] dataOut;
  logic         dataOutVal;
  logic         dataOutReady;
  logic         packetLost;

  int n_cmp = 0;
  int n_err = 0;
  int lost_cnt = 0;
  logic [0:295] rec_q[$];

  always #5 clk = ~clk;

  parser dut (
    .clk(clk), .reset(reset),
    .dataIn(dataIn), .dataInVal(dataInVal), .dataInReady(dataInReady), .dataInLast(dataInLast),
    .dataOut(dataOut), .dataOutVal(dataOutVal), .dataOutReady(dataOutReady),
    .packetLost(packetLost)
  );

  // Capture accepted records and count cycles with packetLost high
  always @(posedge clk) begin
    if (reset && dataOutVal && dataOutReady) rec_q.push_back(dataOut);
    if (packetLost) lost_cnt <= lost_cnt + 1;
  end

  task automatic send(input logic [31:0] w, input logic last);
    int t;
    @(negedge clk);
    dataIn = w; dataInLast = last; dataInVal = 1'b1; t = 0;
    while (!dataInReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: word %h not accepted, dataInReady=%b required 1", w, dataInReady);
    end else begin
      @(posedge clk);
      #1;
    end
    dataInVal = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; dataInVal = 1'b0; dataIn = 32'd0; dataInLast = 1'b0; dataOutReady = 1'b1;
    idle(3);
    n_cmp++; if (dataOutVal !== 1'b0) begin n_err++; $display("FAIL reset_outval: got %b required 0", dataOutVal); end
    n_cmp++; if (packetLost !== 1'b0) begin n_err++; $display("FAIL reset_lost: got %b required 0", packetLost); end
    n_cmp++; if (dataInReady !== 1'b0) begin n_err++; $display("FAIL reset_inready: got %b required 0", dataInReady); end
    n_cmp++; if (dataOut !== 296'd0) begin n_err++; $display("FAIL reset_dataout: got %h required 0", dataOut); end
    reset = 1'b1;
    idle(1);
    n_cmp++; if (dataInReady !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b required 1", dataInReady); end
  endtask

  task automatic test_single;
    logic [0:295] exp;
    int rb, lb;
    rb = rec_q.size(); lb = lost_cnt;
    exp = '0; exp[0:7] = 8'h03; exp[8:31] = 24'hAABBCC;
    send(32'h03AABBCC, 1'b1);
    idle(10);
    n_cmp++; if (rec_q.size() - rb != 1) begin n_err++; $display("FAIL single_count: got %0d required 1", rec_q.size() - rb); end
    n_cmp++; if (rec_q.size() <= rb || rec_q[rb] !== exp) begin n_err++; $display("FAIL single_record: got %h required %h", dataOut, exp); end
    n_cmp++; if (lost_cnt != lb) begin n_err++; $display("FAIL single_lost: got %0d pulses required 0", lost_cnt - lb); end
  endtask

  task automatic test_two_msgs;
    logic [0:295] exp0, exp1;
    int rb, lb;
    rb = rec_q.size(); lb = lost_cnt;
    exp0 = '0; exp0[0:7] = 8'h02; exp0[8:23] = 16'hAABB;
    exp1 = '0; exp1[0:7] = 8'h01; exp1[8:15] = 8'hCC;
    send(32'h02AABB01, 1'b0);
    send(32'hCC000000, 1'b1);
    idle(10);
    n_cmp++; if (rec_q.size() - rb != 2) begin n_err++; $display("FAIL two_count: got %0d required 2", rec_q.size() - rb); end
    n_cmp++; if (rec_q.size() <= rb || rec_q[rb] !== exp0) begin n_err++; $display("FAIL two_rec0: got %h required %h", dataOut, exp0); end
    n_cmp++; if (rec_q.size() <= rb + 1 || rec_q[rb+1] !== exp1) begin n_err++; $display("FAIL two_rec1: got %h required %h", dataOut, exp1); end
    n_cmp++; if (lost_cnt != lb) begin n_err++; $display("FAIL two_lost: got %0d pulses required 0", lost_cnt - lb); end
  endtask

  task automatic test_max_len;
    logic [7:0]   bytes [40];
    logic [0:295] exp;
    int rb, lb;
    rb = rec_q.size(); lb = lost_cnt;
    bytes[0] = 8'h24;
    for (int i = 1; i <= 36; i++) bytes[i] = 8'(i);
    for (int i = 37; i < 40; i++) bytes[i] = 8'h00;
    exp = '0; exp[0:7] = 8'h24;
    for (int k = 0; k < 36; k++) exp[8 + 8*k +: 8] = 8'(k + 1);
    for (int w = 0; w < 10; w++)
      send({bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]}, w == 9);
    idle(10);
    n_cmp++; if (rec_q.size() - rb != 1) begin n_err++; $display("FAIL max_count: got %0d required 1", rec_q.size() - rb); end
    n_cmp++; if (rec_q.size() <= rb || rec_q[rb] !== exp) begin n_err++; $display("FAIL max_record: got %h required %h", dataOut, exp); end
    n_cmp++; if (lost_cnt != lb) begin n_err++; $display("FAIL max_lost: got %0d pulses required 0", lost_cnt - lb); end
  endtask

  task automatic test_errors;
    logic [0:295] exp;
    int rb, lb;
    rb = rec_q.size(); lb = lost_cnt;
    send(32'h05111111, 1'b1);
    idle(10);
    n_cmp++; if (rec_q.size() != rb) begin n_err++; $display("FAIL trunc_count: got %0d required 0", rec_q.size() - rb); end
    n_cmp++; if (lost_cnt - lb != 1) begin n_err++; $display("FAIL trunc_lost: got %0d pulse cycles required 1", lost_cnt - lb); end
    rb = rec_q.size(); lb = lost_cnt;
    exp = '0; exp[0:7] = 8'h01; exp[8:15] = 8'hEE;
    send(32'h25FFFFFF, 1'b0);
    send(32'h12345678, 1'b1);
    send(32'h01EE0000, 1'b1);
    idle(10);
    n_cmp++; if (lost_cnt - lb != 1) begin n_err++; $display("FAIL badlen_lost: got %0d pulse cycles required 1", lost_cnt - lb); end
    n_cmp++; if (rec_q.size() - rb != 1) begin n_err++; $display("FAIL badlen_count: got %0d required 1", rec_q.size() - rb); end
    n_cmp++; if (rec_q.size() <= rb || rec_q[rb] !== exp) begin n_err++; $display("FAIL badlen_record: got %h required %h", dataOut, exp); end
  endtask

  task automatic test_backpressure;
    logic [0:295] exp_a, exp_b;
    int rb, lb;
    rb = rec_q.size(); lb = lost_cnt;
    exp_a = '0; exp_a[0:7] = 8'h01; exp_a[8:15] = 8'hAA;
    exp_b = '0; exp_b[0:7] = 8'h01; exp_b[8:15] = 8'hBB;
    dataOutReady = 1'b0;
    send(32'h01AA01BB, 1'b1);
    idle(10);
    n_cmp++; if (dataOutVal !== 1'b1) begin n_err++; $display("FAIL bp_outval: got %b required 1", dataOutVal); end
    n_cmp++; if (dataOut !== exp_a) begin n_err++; $display("FAIL bp_hold: got %h required %h", dataOut, exp_a); end
    n_cmp++; if (dataInReady !== 1'b0) begin n_err++; $display("FAIL bp_inready: got %b required 0", dataInReady); end
    idle(5);
    n_cmp++; if (dataOut !== exp_a) begin n_err++; $display("FAIL bp_stable: got %h required %h", dataOut, exp_a); end
    dataOutReady = 1'b1;
    idle(10);
    n_cmp++; if (rec_q.size() - rb != 2) begin n_err++; $display("FAIL bp_count: got %0d required 2", rec_q.size() - rb); end
    n_cmp++; if (rec_q.size() <= rb || rec_q[rb] !== exp_a) begin n_err++; $display("FAIL bp_first: got %h required %h", dataOut, exp_a); end
    n_cmp++; if (rec_q.size() <= rb + 1 || rec_q[rb+1] !== exp_b) begin n_err++; $display("FAIL bp_second: got %h required %h", dataOut, exp_b); end
    n_cmp++; if (lost_cnt != lb) begin n_err++; $display("FAIL bp_lost: got %0d pulses required 0", lost_cnt - lb); end
    n_cmp++; if (dataOutVal !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b required 0", dataOutVal); end
  endtask

  task automatic test_reset_mid;
    logic [0:295] exp;
    int rb, lb;
    exp = '0; exp[0:7] = 8'h01; exp[8:15] = 8'h77;
    send(32'h0A112233, 1'b0);
    idle(1);
    reset = 1'b0;
    idle(1);
    n_cmp++; if (dataOutVal !== 1'b0) begin n_err++; $display("FAIL midrst_outval: got %b required 0", dataOutVal); end
    n_cmp++; if (packetLost !== 1'b0) begin n_err++; $display("FAIL midrst_lost: got %b required 0", packetLost); end
    reset = 1'b1;
    rb = rec_q.size(); lb = lost_cnt;
    send(32'h01770000, 1'b1);
    idle(10);
    n_cmp++; if (rec_q.size() - rb != 1) begin n_err++; $display("FAIL midrst_count: got %0d required 1", rec_q.size() - rb); end
    n_cmp++; if (rec_q.size() <= rb || rec_q[rb] !== exp) begin n_err++; $display("FAIL midrst_record: got %h required %h", dataOut, exp); end
    n_cmp++; if (lost_cnt != lb) begin n_err++; $display("FAIL midrst_lost_after: got %0d pulses required 0", lost_cnt - lb); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_msgs();
    test_max_len();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
